// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode/sub-code constants, scoreboard slot
// payload and the hazard-controller FSM state encoding.
package pipe_pkg;

  localparam int unsigned REGW = 4;

  // Opcodes (instruction[15:12])
  localparam logic [3:0] OP_SUB  = 4'd0;
  localparam logic [3:0] OP_MOVL = 4'd8;
  localparam logic [3:0] OP_MOVH = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd14;
  localparam logic [3:0] OP_MEM  = 4'd15;

  // Jump sub-codes
  localparam logic [3:0] JSUB_0 = 4'd0;
  localparam logic [3:0] JSUB_1 = 4'd1;
  localparam logic [3:0] JSUB_2 = 4'd2;
  localparam logic [3:0] JSUB_3 = 4'd3;

  // Memory sub-codes
  localparam logic [3:0] MEM_LD = 4'd0;
  localparam logic [3:0] MEM_ST = 4'd1;

  // One in-flight write tracked per stage
  typedef struct packed {
    logic            v;
    logic            wen;
    logic [REGW-1:0] rt;
  } sb_slot_t;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/execute-side handshake between the pipeline and the hazard controller.
//   master: pipeline (drives decode/execute info, receives control)
//   slave : pipe_hazard_ctrl
interface pipe_hazard_ctrl_if #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned PCW   = 16,
  parameter int unsigned CNTW  = 16
);
  logic             dec_valid;
  logic [3:0]       dec_ra;
  logic [3:0]       dec_r2;
  logic [1:0]       dec_use;
  logic             dec_wen;
  logic [3:0]       dec_rt;
  logic             exe_valid;
  logic             exe_flush;
  logic             exe_halt;
  logic [PCW-1:0]   exe_target;

  logic             stall;
  logic             bubble;
  logic             redirect;
  logic [PCW-1:0]   redirect_pc;
  logic             halted;
  logic [NREGS-1:0] pending;
  logic [CNTW-1:0]  stall_cycles;

  modport master (
    output dec_valid, dec_ra, dec_r2, dec_use, dec_wen, dec_rt,
           exe_valid, exe_flush, exe_halt, exe_target,
    input  stall, bubble, redirect, redirect_pc, halted, pending, stall_cycles
  );

  modport slave (
    input  dec_valid, dec_ra, dec_r2, dec_use, dec_wen, dec_rt,
           exe_valid, exe_flush, exe_halt, exe_target,
    output stall, bubble, redirect, redirect_pc, halted, pending, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Write scoreboard for the D/M/E stages plus the pending-register bitmap.
//   clk, reset : clock, synchronous active-high reset
//   i_flush    : clear every slot at the next edge
//   i_push     : instruction leaves decode this edge (empty slot = bubble)
//   i_wen/i_rt : destination of the issuing instruction
//   o_pending  : registers with a write still in D, M or E (r0 never set)
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned NREGS = 16,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_wen,
  input  logic [REGW-1:0]  i_rt,
  output logic [NREGS-1:0] o_pending
);

  sb_slot_t         r_slots [DEPTH];
  logic [NREGS-1:0] w_pending;

  // Shift toward E; the E slot simply falls off after its write-back cycle
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      for (int i = 0; i < int'(DEPTH); i++) r_slots[i] <= '0;
    end else begin
      r_slots[0] <= '{v: i_push, wen: i_wen, rt: i_rt};
      for (int i = 1; i < int'(DEPTH); i++) r_slots[i] <= r_slots[i-1];
    end
  end

  // r0 writes go to the console, so bit 0 is forced clear
  always_comb begin
    w_pending = '0;
    for (int s = 0; s < int'(DEPTH); s++) begin
      for (int r = 1; r < int'(NREGS); r++) begin
        if (r_slots[s].v && r_slots[s].wen && (r_slots[s].rt == REGW'(r)))
          w_pending[r] = 1'b1;
      end
    end
  end

  assign o_pending = w_pending;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Interlock/redirect controller for the F0/F1/D/M/E pipeline: stalls decode on
// a pending source, bubbles M, redirects on E-stage flush, tracks halt and
// counts stall cycles.
//   clk, reset : clock, synchronous active-high reset
//   bus        : decode/execute info in, stall/bubble/redirect/halted/
//                pending/stall_cycles out
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned NREGS = 16,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned PCW   = 16,
  parameter int unsigned CNTW  = 16
) (
  input  logic clk,
  input  logic reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [0:0] S_RUN    = ST_RUN;
  localparam logic [0:0] S_HALTED = ST_HALTED;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [CNTW-1:0]  r_stall_cycles;
  logic [NREGS-1:0] w_pending;
  logic             w_flush_now;
  logic             w_hazard;
  logic             w_stall;
  logic [PCW-1:0]   w_redirect_pc;

  hazard_scoreboard #(
    .NREGS (NREGS),
    .DEPTH (DEPTH)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .i_flush   (w_flush_now),
    .i_push    (bus.dec_valid & ~w_stall),
    .i_wen     (bus.dec_wen),
    .i_rt      (bus.dec_rt),
    .o_pending (w_pending)
  );

  // No bypass: any read of a register still in D/M/E must wait
  always_comb begin
    w_flush_now   = bus.exe_valid & bus.exe_flush;
    w_redirect_pc = bus.exe_target;
    w_hazard      = bus.dec_valid &
                    ((bus.dec_use[0] & (bus.dec_ra != 4'd0) & w_pending[bus.dec_ra]) |
                     (bus.dec_use[1] & (bus.dec_r2 != 4'd0) & w_pending[bus.dec_r2]));
    w_stall       = w_hazard & ~w_flush_now & (r_state == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:    if (bus.exe_valid && bus.exe_halt) w_state_nxt = S_HALTED;
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_RUN;
    endcase
  end

  // Saturating stall counter; flush does not clear it
  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cycles <= '0;
    else if (w_stall && (r_stall_cycles != {CNTW{1'b1}}))
      r_stall_cycles <= r_stall_cycles + CNTW'(1);
  end

  assign bus.stall        = w_stall;
  assign bus.bubble       = w_stall;
  assign bus.redirect     = w_flush_now;
  assign bus.redirect_pc  = w_redirect_pc;
  assign bus.halted       = (r_state == S_HALTED);
  assign bus.pending      = w_pending;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Interlock and redirect controller for the 5-stage F0/F1/D/M/E pipeline.
- Keeps a scoreboard of register writes in flight in D, M and E.
- Stalls the front end (pc, F1 and D latches) when a decoding instruction sources a pending register, and inserts a bubble into M while stalled.
- Sequences taken-jump/invalid-instruction redirects and the halt state; counts stall cycles for performance debug.

Parameters:
- NREGS, 16, architectural register count; r0 is never tracked.
- DEPTH, 3, scoreboard slots: D, M, E. Slot DEPTH-1 is E, which writes back at the end of its cycle.
- PCW, 16, program-counter width.
- CNTW, 16, stall-counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- dec_valid  in  1  instruction present at F1 output (being decoded this cycle)
- dec_ra  in  4  first source register
- dec_r2  in  4  second source register (rb for sub, rt otherwise)
- dec_use  in  2  bit0: ra is read; bit1: r2 is read
- dec_wen  in  1  instruction writes rt (not jump/store/invalid)
- dec_rt  in  4  destination register
- exe_valid  in  1  E-stage instruction valid
- exe_flush  in  1  E-stage taken jump or invalid opcode
- exe_halt  in  1  E-stage invalid opcode
- exe_target  in  PCW  jump target from E
- stall  out  1  hold pc, F1 and D registers this cycle
- bubble  out  1  force validM low at the next edge
- redirect  out  1  load pc with redirect_pc; clear F0..E valids
- redirect_pc  out  PCW  equals exe_target
- halted  out  1  sticky halt indicator
- pending  out  NREGS  bitmap of registers with an in-flight write
- stall_cycles  out  CNTW  saturating count of stalled cycles

Behaviour:
- Reset: all slots invalid; state RUN; stall, bubble, redirect, halted = 0; pending = 0; stall_cycles = 0; redirect_pc = 0.
- Slot contents: {v, wen, rt}. A slot holds a write only if wen=1 and rt != 0. r0 writes are console output and create no hazard.
- pending[r] is combinational: OR over slots of (v & wen & rt==r). pending[0] is always 0.
- hazard is combinational: dec_valid & ((dec_use[0] & dec_ra!=0 & pending[dec_ra]) | (dec_use[1] & dec_r2!=0 & pending[dec_r2])).
- flush_now = exe_valid & exe_flush. redirect = flush_now; redirect_pc = exe_target. Both are combinational, with zero-cycle latency, consistent with the existing flush path.
- stall = hazard & !flush_now & state==RUN. bubble = stall.
- Slot update at each edge, in priority order:
  - reset: clear all slots.
  - flush_now: clear all slots. The E slot retires normally; jumps never write.
  - otherwise: shift slots toward E. Slot0 gets {dec_valid & !stall, dec_wen, dec_rt}. When stalled, slot0 gets an empty slot, which is the bubble.
- No bypass network: a reader waits until its producer has left E. Minimum dependent distance is 3 stalls for back-to-back instructions.
- FSM has two states:
  - RUN: exe_valid & exe_halt -> HALTED.
  - HALTED: stays until reset.
  - In HALTED: stall = 0, bubble = 0, redirect still follows flush_now, halted = 1 (registered, asserted the cycle after the halting E cycle).
- stall_cycles: increments on each stall cycle and saturates at all-ones. It is not cleared by flush.
- Simultaneous events:
  - flush and hazard in the same cycle: flush wins, no stall, and the stall counter does not increment.
  - halt and flush in the same cycle (invalid opcode): redirect=1 and the FSM moves to HALTED.
  - Reset mid-stall: outputs return to reset values at the next edge.

Decomposition:
- Shared package pipe_pkg holds:
  - opcode constants: SUB=0, MOVL=8, MOVH=9, JMP=14, MEM=15
  - jump sub-codes 0..3; ld/st sub-codes 0/1
  - the scoreboard-slot typedef {v, wen, rt[3:0]}
  - the FSM state enum {RUN, HALTED}
- One sub-module, hazard_scoreboard: the slot shift register plus the pending bitmap. The controller instantiates it and owns the FSM, stall/redirect logic and counter.

Test Plan:
- Reset, then dec_valid=1, dec_rt=3, dec_wen=1 -> next cycle pending=16'h0008, stall=0. Bit clears after 3 cycles with no new writes.
- Write r3, then the next instruction reads r3 (dec_use=1, dec_ra=3) -> stall=bubble=1 for exactly 3 cycles, stall_cycles=3, then issue proceeds.
- Reader sources only r0, or the producer writes r0 (dec_rt=0) -> stall never asserts and pending stays 0.
- r5 pending and hazard active, then exe_valid=1, exe_flush=1, exe_target=16'h0040 -> redirect=1 and redirect_pc=16'h0040 in the same cycle, stall=0, pending=0 at the next edge.
- exe_valid=1, exe_flush=1, exe_halt=1 -> redirect=1 that cycle, halted=1 from the next cycle, stall held 0 despite a later hazard; reset returns halted to 0.
- Force 2^CNTW+5 stall cycles (CNTW overridden to 4) -> stall_cycles saturates at 4'hF.
